scan_sel_gen: RTL
=================

Name: scan_sel_gen

Overview:
- Upstream select sequencer for the 2-to-4 decoder stage.
- Drives the decoder select pair (a = MSB, b = LSB) through slots 0..3 in ascending order, skipping masked slots.
- Each slot is held for a programmable dwell time.
- Runs either one sweep or continuously, and flags sweep completion; used for LED/keypad multiplex scanning.

Parameters:
- DWELL_W, 4, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- stop  input  1  abort immediately; highest priority after reset.
- mode  input  1  0 = single sweep, 1 = continuous; latched at start.
- dwell  input  DWELL_W  each slot is held dwell+1 cycles; latched at start.
- mask  input  4  bit i = 1 enables slot i; latched at start.
- a  output  1  decoder select MSB (slot index bit 1).
- b  output  1  decoder select LSB (slot index bit 0).
- en  output  1  select valid; the decoder output is meaningful only when en = 1.
- busy  output  1  high whenever not IDLE.
- sweep_done  output  1  one-cycle pulse at the end of each full sweep.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; a = b = en = busy = sweep_done = 0; dwell counter = 0; latched mode/dwell/mask = 0.
- States: IDLE and HOLD. All outputs are registered.
- IDLE, start = 1 and mask != 0:
  - latch mode, dwell and mask;
  - next cycle enter HOLD with {a,b} = lowest set bit of mask, counter = 0, en = busy = 1.
- IDLE, start = 1 and mask == 0: ignored; stay IDLE, no sweep_done.
- HOLD, counter < dwell_q: counter increments; {a,b} unchanged.
- HOLD, counter == dwell_q: counter resets to 0 and the slot advances to the next enabled slot with a higher index. Masked slots are skipped with no extra cycles.
- HOLD, no higher enabled slot exists (end of sweep):
  - sweep_done = 1 for one cycle;
  - mode_q = 0: return to IDLE; en = busy = 0 in that same cycle, and {a,b} keeps its last value;
  - mode_q = 1: wrap to the lowest enabled slot; en stays 1 with no gap.
- Slot latency: start at edge k gives first slot valid from cycle k+1. Each slot lasts exactly dwell_q+1 cycles.
- Single sweep total: N*(dwell_q+1) cycles with en = 1, where N = popcount(mask_q).
- stop = 1 in any state:
  - next cycle state is IDLE, en = busy = 0, counter = 0, sweep_done = 0;
  - start is ignored when stop = 1 in the same cycle.
- start while busy: ignored. Changes on mask/dwell/mode while busy: no effect until the next start.
- Single-slot mask (e.g. 4'b0100) in continuous mode: slot 2 held indefinitely; sweep_done pulses every dwell_q+1 cycles.
- dwell = 0: slot changes every cycle.
- dwell = all-ones: 2^DWELL_W cycles per slot; the counter never overflows past dwell_q.
- Reset mid-sweep: immediate return to reset values; no sweep_done.
- Widths: slot index is 2 bits; next-slot search is combinational over mask_q and the current index.

Test Plan:
- Reset then idle: rst_n = 0 for 2 cycles, then 1 with start = 0 -> a = b = en = busy = sweep_done = 0 throughout.
- Full single sweep: mask = 4'b1111, dwell = 1, mode = 0, start pulse at edge k ->
  - {a,b} = 00 (cycles k+1..k+2), 01, 10, 11, two cycles each;
  - sweep_done = 1 and en = 0 at k+9;
  - busy low from k+9.
- Masked continuous: mask = 4'b1010, dwell = 0, mode = 1 ->
  - {a,b} = 01, 11, 01, 11, ... every cycle;
  - sweep_done high on each 11 -> 01 wrap cycle;
  - en never drops.
- Stop mid-sweep: mask = 4'b1111, dwell = 3, stop asserted while {a,b} = 10 -> next cycle en = busy = 0, no sweep_done; a later start restarts from slot 00.
- Edge cases:
  - start with mask = 0 -> no activity;
  - start while busy with changed mask -> sequence unaffected;
  - start and stop together in IDLE -> stays IDLE.
- Async reset mid-HOLD: drop rst_n between clock edges -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/scan_sel_gen.sv
// Select sequencer for a 2-to-4 decoder: walks enabled slots 0..3 in ascending
// order, holding each for dwell+1 cycles, as a single sweep or continuously.
module scan_sel_gen #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic               a,
  output logic               b,
  output logic               en,
  output logic               busy,
  output logic               sweep_done
);

  localparam int unsigned SLOT_W = 2;
  localparam int unsigned NSLOT  = 4;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [SLOT_W-1:0]  slot;
  logic [DWELL_W-1:0] cnt;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [NSLOT-1:0]   mask_q;

  logic               nxt_found;
  logic [SLOT_W-1:0]  nxt_slot;
  logic [SLOT_W-1:0]  start_slot;
  logic [SLOT_W-1:0]  wrap_slot;

  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NSLOT-1:0] m);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m[i]) r = SLOT_W'(i);
    end
    return r;
  endfunction

  // Next enabled slot strictly above the current one; found=0 marks end of sweep.
  always_comb begin
    nxt_found = 1'b0;
    nxt_slot  = slot;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(slot))) begin
        nxt_found = 1'b1;
        nxt_slot  = SLOT_W'(i);
      end
    end
    start_slot = lowest_set(mask);
    wrap_slot  = lowest_set(mask_q);
  end

  assign a = slot[1];
  assign b = slot[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot       <= '0;
      cnt        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      mode_q     <= 1'b0;
      dwell_q    <= '0;
      mask_q     <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        en    <= 1'b0;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (mask != '0)) begin
              mode_q  <= mode;
              dwell_q <= dwell;
              mask_q  <= mask;
              slot    <= start_slot;
              cnt     <= '0;
              en      <= 1'b1;
              busy    <= 1'b1;
              state   <= HOLD;
            end
          end
          HOLD: begin
            if (cnt != dwell_q) begin
              cnt <= cnt + DWELL_W'(1);
            end else begin
              cnt <= '0;
              if (nxt_found) begin
                slot <= nxt_slot;
              end else begin
                sweep_done <= 1'b1;
                if (mode_q) begin
                  slot <= wrap_slot;
                end else begin
                  // Single sweep ends: select pair keeps its last value.
                  state <= IDLE;
                  en    <= 1'b0;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
